// File: rtl/maxpool_pkg.sv
// Shared types for the 2x nearest-neighbour upsampler.
package maxpool_pkg;

  localparam int unsigned PIXEL_W = 8;

  typedef logic signed [PIXEL_W-1:0] pixel_t;

  typedef enum logic {
    FILL   = 1'b0,
    REPLAY = 1'b1
  } upsample_state_t;

endpackage

// File: rtl/upsample_row_buf.sv
// One-row pixel store: written while a row streams in, read back for the repeated row.
module upsample_row_buf
  import maxpool_pkg::*;
#(
  parameter int unsigned DEPTH  = 14,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data
);

  pixel_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= $signed(wr_data);
    end
  end

  // Combinational read; the top registers the result into its output stage.
  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/maxpool_upsampler.sv
// Streaming 2x nearest-neighbour upsampler: each pixel emitted twice, each row emitted twice.
module maxpool_upsampler
  import maxpool_pkg::*;
#(
  parameter int unsigned IN_WIDTH  = 14,
  parameter int unsigned IN_HEIGHT = 14
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] pixel_in,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] pixel_out,
  output logic       out_last_col,
  output logic       out_frame_end
);

  localparam int unsigned COL_W = (IN_WIDTH  > 1) ? $clog2(IN_WIDTH)  : 1;
  localparam int unsigned ROW_W = (IN_HEIGHT > 1) ? $clog2(IN_HEIGHT) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IN_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IN_HEIGHT - 1);

  upsample_state_t  state_q, state_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic             dup_q, dup_d;
  logic             out_valid_q, out_valid_d;
  pixel_t           pixel_out_q, pixel_out_d;
  logic             last_col_q, last_col_d;
  logic             frame_end_q, frame_end_d;

  logic             slot_free_c;
  logic             in_xfer_c;
  logic             at_last_col_c;
  logic             buf_wr_en_c;
  logic [7:0]       buf_rd_data;

  upsample_row_buf #(
    .DEPTH  (IN_WIDTH),
    .ADDR_W (COL_W)
  ) u_row_buf (
    .clk     (clk),
    .wr_en   (buf_wr_en_c),
    .wr_addr (col_q),
    .wr_data (pixel_in),
    .rd_addr (col_q),
    .rd_data (buf_rd_data)
  );

  assign slot_free_c   = !out_valid_q || out_ready;
  assign in_ready      = (state_q == FILL) && !dup_q && slot_free_c;
  assign in_xfer_c     = in_valid && in_ready;
  assign at_last_col_c = (col_q == COL_LAST);

  // Next-state and output-stage logic; nothing moves while the output slot is stalled.
  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    dup_d       = dup_q;
    out_valid_d = out_valid_q;
    pixel_out_d = pixel_out_q;
    last_col_d  = last_col_q;
    frame_end_d = frame_end_q;
    buf_wr_en_c = 1'b0;

    if (slot_free_c) begin
      case (state_q)
        FILL: begin
          if (dup_q) begin
            out_valid_d = 1'b1;
            dup_d       = 1'b0;
            last_col_d  = at_last_col_c;
            frame_end_d = 1'b0;
            if (at_last_col_c) begin
              col_d   = '0;
              state_d = REPLAY;
            end else begin
              col_d = col_q + COL_W'(1);
            end
          end else if (in_xfer_c) begin
            out_valid_d = 1'b1;
            pixel_out_d = $signed(pixel_in);
            buf_wr_en_c = 1'b1;
            dup_d       = 1'b1;
            last_col_d  = 1'b0;
            frame_end_d = 1'b0;
          end else begin
            out_valid_d = 1'b0;
            last_col_d  = 1'b0;
            frame_end_d = 1'b0;
          end
        end
        REPLAY: begin
          out_valid_d = 1'b1;
          pixel_out_d = $signed(buf_rd_data);
          if (!dup_q) begin
            dup_d       = 1'b1;
            last_col_d  = 1'b0;
            frame_end_d = 1'b0;
          end else begin
            dup_d       = 1'b0;
            last_col_d  = at_last_col_c;
            frame_end_d = at_last_col_c && (row_q == ROW_LAST);
            if (at_last_col_c) begin
              col_d   = '0;
              row_d   = (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
              state_d = FILL;
            end else begin
              col_d = col_q + COL_W'(1);
            end
          end
        end
        default: state_d = FILL;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FILL;
      col_q       <= '0;
      row_q       <= '0;
      dup_q       <= 1'b0;
      out_valid_q <= 1'b0;
      pixel_out_q <= '0;
      last_col_q  <= 1'b0;
      frame_end_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      dup_q       <= dup_d;
      out_valid_q <= out_valid_d;
      pixel_out_q <= pixel_out_d;
      last_col_q  <= last_col_d;
      frame_end_q <= frame_end_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign pixel_out     = pixel_out_q;
  assign out_last_col  = last_col_q;
  assign out_frame_end = frame_end_q;

endmodule

// File: tb/tb_maxpool_upsampler.sv
// Directed + randomized bench for maxpool_upsampler with a frame-level reference model.
module tb_maxpool_upsampler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] pixel_in = 8'h00;
  logic       out_ready = 1'b0;
  bit         sel = 1'b0;

  logic       s_in_ready, s_out_valid, s_lc, s_fe;
  logic [7:0] s_po;
  logic       d_in_ready, d_out_valid, d_lc, d_fe;
  logic [7:0] d_po;
  logic       m_ir, m_ov, m_lc, m_fe;
  logic [7:0] m_po;

  maxpool_upsampler #(.IN_WIDTH(2), .IN_HEIGHT(2)) dut_s (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (s_in_ready),
    .pixel_in      (pixel_in),
    .out_valid     (s_out_valid),
    .out_ready     (out_ready),
    .pixel_out     (s_po),
    .out_last_col  (s_lc),
    .out_frame_end (s_fe)
  );

  maxpool_upsampler dut_d (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (d_in_ready),
    .pixel_in      (pixel_in),
    .out_valid     (d_out_valid),
    .out_ready     (out_ready),
    .pixel_out     (d_po),
    .out_last_col  (d_lc),
    .out_frame_end (d_fe)
  );

  assign m_ir = sel ? d_in_ready  : s_in_ready;
  assign m_ov = sel ? d_out_valid : s_out_valid;
  assign m_lc = sel ? d_lc        : s_lc;
  assign m_fe = sel ? d_fe        : s_fe;
  assign m_po = sel ? d_po        : s_po;

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] px;
    logic       lc;
    logic       fe;
  } exp_t;

  int   frame_in[$];
  exp_t expq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: output frame derived directly from the replication rules.
  task automatic build_expected(input int w, input int h);
    expq.delete();
    for (int r = 0; r < h; r++)
      for (int rep = 0; rep < 2; rep++)
        for (int c = 0; c < w; c++)
          for (int d = 0; d < 2; d++) begin
            exp_t e;
            e.px = 8'(frame_in[r * w + c]);
            e.lc = (c == w - 1) && (d == 1);
            e.fe = e.lc && (rep == 1) && (r == h - 1);
            expq.push_back(e);
          end
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    repeat (cycles) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset out_valid", {31'd0, m_ov}, 32'd0);
    chk("reset pixel_out", {24'd0, m_po}, 32'd0);
    chk("reset in_ready", {31'd0, m_ir}, 32'd1);
  endtask

  task automatic run_frame(input int w, input int h, input int ready_pct, input int gap_at,
                           input int abort_after, input bit check_consec, input string name);
    int n, total, limit, in_idx, out_idx, cyc, first, last, fe_cnt;
    int gap_left, gap_valid;
    bit gap_active, gap_done, prev_stall;
    logic [9:0] held;
    n = w * h;
    build_expected(w, h);
    total = expq.size();
    limit = (abort_after > 0) ? abort_after : total;
    in_idx = 0; out_idx = 0; cyc = 0; first = -1; last = -1; fe_cnt = 0;
    gap_left = 0; gap_valid = 0; gap_active = 0; gap_done = 0; prev_stall = 0;
    held = '0;
    while (out_idx < limit && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (gap_active && m_ov) gap_valid++;
      if (prev_stall)
        chk({name, " stall hold"}, {22'd0, m_lc, m_fe, m_po}, {22'd0, held});
      if (!gap_done && gap_at > 0 && in_idx == gap_at) begin
        gap_left = 5;
        gap_done = 1'b1;
      end
      if (gap_left > 0) begin
        in_valid = 1'b0;
        gap_left--;
        gap_active = 1'b1;
      end else begin
        in_valid = (in_idx < n);
        gap_active = 1'b0;
      end
      pixel_in = (in_idx < n) ? 8'(frame_in[in_idx]) : 8'h00;
      out_ready = ($urandom_range(99) < ready_pct);
      #1;
      if (m_ov && !out_ready) begin
        chk({name, " in_ready in stall"}, {31'd0, m_ir}, 32'd0);
        prev_stall = 1'b1;
        held = {m_lc, m_fe, m_po};
      end else begin
        prev_stall = 1'b0;
      end
      if (m_ov && out_ready) begin
        chk({name, " out"}, {22'd0, m_lc, m_fe, m_po},
            {22'd0, expq[out_idx].lc, expq[out_idx].fe, expq[out_idx].px});
        if (first < 0) first = cyc;
        last = cyc;
        if (m_fe) fe_cnt++;
        out_idx++;
      end
      if (in_valid && m_ir) in_idx++;
    end
    in_valid = 1'b0;
    chk({name, " outputs within budget"}, out_idx, limit);
    if (abort_after == 0) chk({name, " frame_end count"}, fe_cnt, 1);
    if (gap_at > 0) chk({name, " valid cycles in gap"}, gap_valid, 1);
    if (check_consec) chk({name, " consecutive span"}, last - first, total - 1);
  endtask

  initial begin
    sel = 1'b0;
    do_reset(3);
    chk("reset default in_ready", {31'd0, d_in_ready}, 32'd1);
    chk("reset default out_valid", {31'd0, d_out_valid}, 32'd0);

    frame_in = '{1, 2, 3, 4};
    run_frame(2, 2, 100, 0, 0, 1'b1, "s_b2b");
    run_frame(2, 2, 50, 0, 0, 1'b0, "s_rand_ready");
    frame_in.delete();
    for (int i = 0; i < 4; i++) frame_in.push_back(int'($urandom_range(255)) - 128);
    run_frame(2, 2, 50, 0, 0, 1'b0, "s_rand_data");

    sel = 1'b1;
    do_reset(3);
    frame_in.delete();
    for (int i = 0; i < 196; i++) begin
      case (i % 4)
        0: frame_in.push_back(-128);
        1: frame_in.push_back(127);
        2: frame_in.push_back(0);
        default: frame_in.push_back(-1);
      endcase
    end
    run_frame(14, 14, 100, 0, 0, 1'b1, "d_pattern");
    frame_in.delete();
    for (int i = 0; i < 196; i++) frame_in.push_back(int'($urandom_range(255)) - 128);
    run_frame(14, 14, 60, 0, 0, 1'b0, "d_rand");
    frame_in.delete();
    for (int i = 0; i < 196; i++) frame_in.push_back(int'($urandom_range(255)) - 128);
    run_frame(14, 14, 100, 5, 0, 1'b0, "d_gap");

    sel = 1'b0;
    do_reset(3);
    frame_in = '{1, 2, 3, 4};
    run_frame(2, 2, 100, 0, 13, 1'b0, "s_abort");
    rst = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("abort out_valid", {31'd0, m_ov}, 32'd0);
    chk("abort pixel_out", {24'd0, m_po}, 32'd0);
    rst = 1'b0;
    #1;
    chk("abort in_ready", {31'd0, m_ir}, 32'd1);
    frame_in = '{9, 8, 7, 6};
    run_frame(2, 2, 100, 0, 0, 1'b1, "s_after_abort");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
